// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: widths, NOP, reset vector, FSM states.
package fetch_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP       = '0;
    localparam logic [PC_W-1:0]    RESET_VEC = '0;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

    // Payload carried in the IF/ID slot
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ifid_t;

    // Word-address increment; wraps naturally at the PC width
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q,
    output logic  valid
);

    // Slot update; a flush keeps the old pc but clears instr/valid
    always_ff @(posedge clock) begin
        if (!reset) begin
            q.instr <= NOP;
            q.pc    <= RESET_VEC;
            valid   <= 1'b0;
        end else if (flush) begin
            q.instr <= NOP;
            valid   <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, BOOT/RUN/HALT control and delivered-instruction counter.
// imem is read on the falling edge, so q_imem for address_imem is ready by the
// next rising edge and lands in the IF/ID slot with one cycle of latency.
module instr_fetch
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [PC_W-1:0]    address_imem,
    input  logic [INSTR_W-1:0] q_imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_pc_plus1,
    output logic [31:0]        fetch_count
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            load, flush;
    ifid_t           slot_d, slot_q;

    // State, PC and counter registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_VEC;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load) fetch_count <= fetch_count + 32'd1;
        end
    end

    // Next state, next PC and slot control; priority redirect > halt_req > stall
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load      = 1'b0;
        flush     = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                    flush  = 1'b1;
                end else if (halt_req) begin
                    state_nxt = ST_HALT;
                    flush     = 1'b1;
                end else if (!stall) begin
                    pc_nxt = pc_inc(pc);
                    load   = 1'b1;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = redirect_pc;
                    flush     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
                pc_nxt    = RESET_VEC;
            end
        endcase
    end

    assign slot_d.instr = q_imem;
    assign slot_d.pc    = pc;

    if_id_reg u_if_id (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .flush (flush),
        .d     (slot_d),
        .q     (slot_q),
        .valid (if_valid)
    );

    assign address_imem = pc;
    assign if_instr     = slot_q.instr;
    assign if_pc        = slot_q.pc;
    assign if_pc_plus1  = pc_inc(slot_q.pc);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a falling-edge imem model.
module tb_instr_fetch;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [11:0] if_pc;
    logic [11:0] if_pc_plus1;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:4095];
    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt_req     (halt_req),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus1  (if_pc_plus1),
        .fetch_count  (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imem is clocked on the falling edge
    always @(negedge clock) q_imem = mem[address_imem];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full set of reset-state checks
    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_instr"}, if_instr, 32'd0);
        chk({tag, "_pc"},    {20'd0, if_pc}, 32'd0);
        chk({tag, "_cnt"},   fetch_count, 32'd0);
        chk({tag, "_addr"},  {20'd0, address_imem}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000 + i;
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
        q_imem = '0;
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_req = 1'b0;

        step(); step();
        chk_reset("rst");
        reset = 1'b1;
        step();                                         // BOOT -> RUN
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        chk("boot_addr", {20'd0, address_imem}, 32'd0);

        step();
        chk("f0_instr", if_instr, 32'd11);
        chk("f0_pc", {20'd0, if_pc}, 32'd0);
        chk("f0_valid", {31'd0, if_valid}, 32'd1);
        step();
        chk("f1_instr", if_instr, 32'd22);
        step();
        chk("f2_instr", if_instr, 32'd33);
        chk("f2_pc", {20'd0, if_pc}, 32'd2);

        // stall for three cycles while if_pc=2
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", {20'd0, if_pc}, 32'd2);
            chk("stall_instr", if_instr, 32'd33);
            chk("stall_cnt", fetch_count, 32'd3);
            chk("stall_addr", {20'd0, address_imem}, 32'd3);
        end
        stall = 1'b0;
        step();
        chk("f3_instr", if_instr, 32'd44);
        chk("f3_cnt", fetch_count, 32'd4);
        step();
        chk("f4_pc", {20'd0, if_pc}, 32'd4);
        chk("f4_instr", if_instr, 32'h1004);

        // redirect wins over stall
        redirect = 1'b1; redirect_pc = 12'd100; stall = 1'b1;
        step();
        chk("rd_valid", {31'd0, if_valid}, 32'd0);
        chk("rd_instr", if_instr, 32'd0);
        chk("rd_addr", {20'd0, address_imem}, 32'd100);
        chk("rd_cnt", fetch_count, 32'd5);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("rd1_pc", {20'd0, if_pc}, 32'd100);
        chk("rd1_valid", {31'd0, if_valid}, 32'd1);
        chk("rd1_instr", if_instr, 32'h1064);
        chk("rd1_plus1", {20'd0, if_pc_plus1}, 32'd101);

        // PC wrap at 4095
        redirect = 1'b1; redirect_pc = 12'd4095;
        step();
        chk("wr_addr", {20'd0, address_imem}, 32'd4095);
        redirect = 1'b0;
        step();
        chk("wr_pc", {20'd0, if_pc}, 32'd4095);
        chk("wr_plus1", {20'd0, if_pc_plus1}, 32'd0);
        chk("wr_addr0", {20'd0, address_imem}, 32'd0);
        step();
        chk("wr1_pc", {20'd0, if_pc}, 32'd0);
        chk("wr1_instr", if_instr, 32'd11);

        // halt at PC=7
        redirect = 1'b1; redirect_pc = 12'd5;
        step();
        redirect = 1'b0;
        step(); step();
        chk("pre_halt_addr", {20'd0, address_imem}, 32'd7);
        chk("pre_halt_cnt", fetch_count, 32'd10);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_instr", if_instr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            stall    = i[0];
            halt_req = i[1];
            step();
            chk("halt_hold_valid", {31'd0, if_valid}, 32'd0);
            chk("halt_hold_addr", {20'd0, address_imem}, 32'd7);
            chk("halt_hold_cnt", fetch_count, 32'd10);
        end
        stall = 1'b0; halt_req = 1'b0;
        redirect = 1'b1; redirect_pc = 12'd20;
        step();
        chk("unhalt_addr", {20'd0, address_imem}, 32'd20);
        chk("unhalt_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0;
        step();
        chk("unhalt_pc", {20'd0, if_pc}, 32'd20);
        chk("unhalt_valid1", {31'd0, if_valid}, 32'd1);
        chk("unhalt_cnt", fetch_count, 32'd11);

        // reset during stall; redirect during BOOT is ignored
        stall = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_reset("rst_stall");
        reset = 1'b1; stall = 1'b0; redirect = 1'b1; redirect_pc = 12'd50;
        step();
        chk("boot_rd_addr", {20'd0, address_imem}, 32'd0);
        chk("boot_rd_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0;
        step();
        chk("rs_f0_instr", if_instr, 32'd11);
        chk("rs_f0_pc", {20'd0, if_pc}, 32'd0);

        // reset during HALT
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("h2_valid", {31'd0, if_valid}, 32'd0);
        reset = 1'b0;
        step();
        chk_reset("rst_halt");
        reset = 1'b1;
        step(); step();
        chk("rh_f0_instr", if_instr, 32'd11);
        chk("rh_f0_cnt", fetch_count, 32'd1);
        step();
        chk("rh_f1_instr", if_instr, 32'd22);
        chk("rh_f1_pc", {20'd0, if_pc}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have ports: clock  in  1  master clock, rising-edge active; imem is clocked on ~clock.
REQ-002 SHALL have: reset  in  1  synchronous, active-low; sampled on rising clock edge.
REQ-003 SHALL have: address_imem  out  12  current PC, word address into imem.
REQ-004 SHALL have: q_imem  in  32  instruction returned by imem for address_imem, valid before next rising edge.
REQ-005 SHALL have: stall  in  1  decode back-pressure; hold PC and IF/ID outputs.
REQ-006 SHALL have: redirect  in  1  branch/jump taken; load redirect_pc and flush IF/ID.
REQ-007 SHALL have: redirect_pc  in  12  redirect target word address.
REQ-008 SHALL have: halt_req  in  1  stop fetching until redirect or reset.
REQ-009 SHALL have: if_valid  out  1  IF/ID slot holds a real instruction.
REQ-010 SHALL have: if_instr  out  32  fetched instruction; NOP (32'h0000_0000) when not valid.
REQ-011 SHALL have: if_pc  out  12  address of if_instr.
REQ-012 SHALL have: if_pc_plus1  out  12  if_pc + 1, modulo 4096, for link/branch base.
REQ-013 SHALL have: fetch_count  out  32  number of instructions delivered valid, saturating-free wrap.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, HALT.
REQ-015 BOOT: entered on reset; PC=0 presented; if_valid=0; next state RUN unconditionally.
REQ-016 RUN, no stall/redirect: PC <= PC+1 (12-bit wrap 4095->0); if_instr <= q_imem; if_pc <= PC; if_valid <= 1; fetch_count += 1.
REQ-017 Fetch latency SHALL be one cycle: instruction at address A appears on if_instr on the edge after A is driven.
REQ-018 RUN, stall=1, redirect=0: PC, if_instr, if_pc, if_valid, fetch_count SHALL hold.
REQ-019 redirect=1 (any state except BOOT): PC <= redirect_pc; if_valid <= 0; if_instr <= NOP; next state RUN.
REQ-020 Priority SHALL be reset > redirect > halt_req > stall.
REQ-021 RUN, halt_req=1, redirect=0: next state HALT; the instruction at current PC is not delivered; if_valid <= 0; PC holds.
REQ-022 HALT: PC holds; if_valid=0; stall and halt_req ignored; exit only via redirect (to RUN) or reset (to BOOT).
REQ-023 redirect during BOOT SHALL be ignored.
REQ-024 fetch_count SHALL increment only on cycles where if_valid is loaded with 1; wraps 2^32-1 -> 0.
REQ-025 if_pc_plus1 SHALL be combinational from registered if_pc.

Reset
REQ-026 On reset=0 at a rising edge: state=BOOT, PC=0, if_valid=0, if_instr=NOP, if_pc=0, fetch_count=0; overrides all other inputs, including mid-stall or mid-HALT.
REQ-027 address_imem SHALL read 0 in the cycle following a reset edge.

Structure
REQ-028 Shared package fetch_pkg SHALL hold: PC width (12), instruction width (32), NOP encoding, reset vector (0), FSM state enum.
REQ-029 IF/ID pipeline register (instr, pc, valid with load/flush/hold) SHALL be sub-module if_id_reg; PC and FSM stay in instr_fetch.

Verification
REQ-030 Reset then free-run, imem[0..3]=11,22,33,44: if_instr = 11,22,33,44 on cycles 2..5 after reset release; if_pc = 0..3; fetch_count=4.
REQ-031 stall high 3 cycles while if_pc=2: if_instr/if_pc/fetch_count frozen 3 cycles, then resume with PC=4 fetched next.
REQ-032 redirect=1, redirect_pc=100 with stall=1 same cycle: next cycle if_valid=0, address_imem=100; following cycle if_pc=100, if_valid=1.
REQ-033 PC=4095 free-run: if_pc sequence 4095 -> 0; if_pc_plus1 at 4095 equals 0.
REQ-034 halt_req pulse at PC=7: if_valid=0 indefinitely, address_imem stays 7; redirect to 20 resumes with if_pc=20 one cycle later.
REQ-035 reset=0 asserted during HALT and during stall: next edge all outputs at REQ-026 values, state BOOT, then normal fetch from 0.
